// File: rtl/pgm_rd_pkg.sv
// Shared definitions for the PGM read stage: FSM states, packet word-type tags
// and PGM_RAM geometry.
package pgm_rd_pkg;

  localparam int unsigned RAM_DEPTH = 128;
  localparam int unsigned RAM_WIDTH = 144;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 134;
  localparam int unsigned PHV_W     = 1024;

  localparam logic [1:0] WT_HEAD = 2'b01;
  localparam logic [1:0] WT_BODY = 2'b11;
  localparam logic [1:0] WT_TAIL = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BYPASS,
    ST_RD,
    ST_GAP,
    ST_DRAIN
  } state_e;

  function automatic logic [1:0] word_type(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pgm_rd_if.sv
// Packet-stream bundle around pgm_rd: bypass input side, downstream output side
// and the almost-full pair. master = pgm_rd's view, slave = its environment.
interface pgm_rd_if;
  import pgm_rd_pkg::*;

  logic [PHV_W-1:0]  in_rd_phv;
  logic              in_rd_phv_wr;
  logic [DATA_W-1:0] in_rd_data;
  logic              in_rd_data_wr;
  logic              in_rd_valid;
  logic              in_rd_valid_wr;
  logic              in_rd_alf;
  logic              out_rd_alf;

  logic [PHV_W-1:0]  out_rd_phv;
  logic              out_rd_phv_wr;
  logic [DATA_W-1:0] out_rd_data;
  logic              out_rd_data_wr;
  logic              out_rd_valid;
  logic              out_rd_valid_wr;

  modport master (
    input  in_rd_phv, in_rd_phv_wr, in_rd_data, in_rd_data_wr,
           in_rd_valid, in_rd_valid_wr, in_rd_alf,
    output out_rd_alf, out_rd_phv, out_rd_phv_wr, out_rd_data,
           out_rd_data_wr, out_rd_valid, out_rd_valid_wr
  );

  modport slave (
    output in_rd_phv, in_rd_phv_wr, in_rd_data, in_rd_data_wr,
           in_rd_valid, in_rd_valid_wr, in_rd_alf,
    input  out_rd_alf, out_rd_phv, out_rd_phv_wr, out_rd_data,
           out_rd_data_wr, out_rd_valid, out_rd_valid_wr
  );

endinterface

// File: rtl/pgm_rd.sv
// PGM read stage: forwards bypass packets or replays stored packets from PGM_RAM.
// Define PGM_RD_SEQ_STAMP_EN to stamp generated headers with the packet sequence number.
module pgm_rd
  import pgm_rd_pkg::*;
#(
  parameter             PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PHV_W-1:0]     in_rd_phv,
  input  logic                 in_rd_phv_wr,
  input  logic [DATA_W-1:0]    in_rd_data,
  input  logic                 in_rd_data_wr,
  input  logic                 in_rd_valid,
  input  logic                 in_rd_valid_wr,
  output logic                 out_rd_alf,
  input  logic                 pgm_bypass_flag,
  input  logic                 pgm_sent_start_flag,
  input  logic                 pgm_sent_finish_flag,
  output logic                 rd2ram_rd_en,
  output logic [ADDR_W-1:0]    rd2ram_addr,
  input  logic [RAM_WIDTH-1:0] ram2rd_rdata,
  output logic [PHV_W-1:0]     out_rd_phv,
  output logic                 out_rd_phv_wr,
  output logic [DATA_W-1:0]    out_rd_data,
  output logic                 out_rd_data_wr,
  output logic                 out_rd_valid,
  output logic                 out_rd_valid_wr,
  input  logic                 in_rd_alf,
  output logic [63:0]          gen_pkt_cnt
);

  localparam logic [7:0] unused_lmid          = LMID;
  localparam int         unused_platform_bits = $bits(PLATFORM);

  state_e            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvld_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              fin_pend_q, fin_pend_d;
  logic [63:0]       cnt_q, cnt_d;
  logic [PHV_W-1:0]  phv_q, phv_d;
  logic              phv_wr_q, phv_wr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_wr_q, data_wr_d;
  logic              valid_q, valid_d;
  logic              valid_wr_q, valid_wr_d;

  logic [DATA_W-1:0] rword;
  logic              fwd;
  logic              is_last;
  logic              unused_rdata;

  assign unused_rdata = ^ram2rd_rdata[RAM_WIDTH-1:DATA_W];
  assign out_rd_alf   = in_rd_alf;

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    fin_pend_d = fin_pend_q;
    cnt_d      = cnt_q;
    phv_d      = phv_q;
    phv_wr_d   = 1'b0;
    data_d     = data_q;
    data_wr_d  = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;
    rword      = ram2rd_rdata[DATA_W-1:0];
    is_last    = 1'b0;

    // The word that opens a bypass packet is forwarded in IDLE itself.
    fwd = (state_q == ST_BYPASS) ||
          (state_q == ST_IDLE && pgm_bypass_flag && in_rd_data_wr);
    if (fwd) begin
      phv_d      = in_rd_phv;
      phv_wr_d   = in_rd_phv_wr;
      data_d     = in_rd_data;
      data_wr_d  = in_rd_data_wr;
      valid_d    = in_rd_valid;
      valid_wr_d = in_rd_valid_wr;
    end

    unique case (state_q)
      ST_IDLE: begin
        fin_pend_d = 1'b0;
        if (pgm_bypass_flag && in_rd_data_wr) begin
          if (word_type(in_rd_data) != WT_TAIL) state_d = ST_BYPASS;
        end else if (pgm_sent_start_flag && !pgm_sent_finish_flag) begin
          if (in_rd_alf) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_RD;
            rd_en_d = 1'b1;
            addr_d  = '0;
          end
        end
      end

      ST_BYPASS: begin
        if (in_rd_data_wr && word_type(in_rd_data) == WT_TAIL) state_d = ST_IDLE;
      end

      ST_RD: begin
        if (pgm_sent_finish_flag) fin_pend_d = 1'b1;
        rd_en_d = rd_en_q && (addr_q != ADDR_LAST);
        if (rd_en_q) addr_d = addr_q + ADDR_W'(1);
        // Reads run one word ahead of the tail check; the extra read is discarded.
        if (rvld_q) begin
          if (word_type(rword) == WT_HEAD) begin
            phv_d    = '0;
            phv_wr_d = 1'b1;
`ifdef PGM_RD_SEQ_STAMP_EN
            rword[31:0] = cnt_q[31:0];
`endif
          end
          is_last = (word_type(rword) == WT_TAIL) || (raddr_q == ADDR_LAST);
          if (is_last) begin
            rword[DATA_W-1 -: 2] = WT_TAIL;
            valid_d    = 1'b1;
            valid_wr_d = 1'b1;
            cnt_d      = cnt_q + 64'd1;
            rd_en_d    = 1'b0;
            addr_d     = '0;
            state_d    = (fin_pend_q || pgm_sent_finish_flag) ? ST_DRAIN : ST_GAP;
          end
          data_d    = rword;
          data_wr_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (pgm_sent_finish_flag) begin
          state_d = ST_IDLE;
        end else if (!in_rd_alf) begin
          state_d = ST_RD;
          rd_en_d = 1'b1;
          addr_d  = '0;
        end
      end

      ST_DRAIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      rvld_q     <= 1'b0;
      raddr_q    <= '0;
      fin_pend_q <= 1'b0;
      cnt_q      <= '0;
      phv_q      <= '0;
      phv_wr_q   <= 1'b0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      rvld_q     <= rd_en_q;
      raddr_q    <= addr_q;
      fin_pend_q <= fin_pend_d;
      cnt_q      <= cnt_d;
      phv_q      <= phv_d;
      phv_wr_q   <= phv_wr_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
    end
  end

  assign rd2ram_rd_en    = rd_en_q;
  assign rd2ram_addr     = addr_q;
  assign out_rd_phv      = phv_q;
  assign out_rd_phv_wr   = phv_wr_q;
  assign out_rd_data     = data_q;
  assign out_rd_data_wr  = data_wr_q;
  assign out_rd_valid    = valid_q;
  assign out_rd_valid_wr = valid_wr_q;
  assign gen_pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_pgm_rd.sv
// Directed bench for pgm_rd with a behavioural PGM_RAM and a word/PHV scoreboard.
module tb_pgm_rd;
  import pgm_rd_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pgm_rd_if bus ();

  logic         start, finish, bypass;
  logic         rd_en;
  logic [6:0]   addr;
  logic [143:0] rdata = '0;
  logic [63:0]  cnt;
  logic [143:0] mem [128];

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int cyc = 0;
  int last_tail = -1;

  logic [134:0]  exp_q[$], obs_q[$];
  logic [1023:0] exp_phv_q[$], obs_phv_q[$];
  int            gap_q[$];

  pgm_rd #(.PLATFORM("Xilinx"), .LMID(8'd63)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rd_phv(bus.in_rd_phv), .in_rd_phv_wr(bus.in_rd_phv_wr),
    .in_rd_data(bus.in_rd_data), .in_rd_data_wr(bus.in_rd_data_wr),
    .in_rd_valid(bus.in_rd_valid), .in_rd_valid_wr(bus.in_rd_valid_wr),
    .out_rd_alf(bus.out_rd_alf),
    .pgm_bypass_flag(bypass), .pgm_sent_start_flag(start), .pgm_sent_finish_flag(finish),
    .rd2ram_rd_en(rd_en), .rd2ram_addr(addr), .ram2rd_rdata(rdata),
    .out_rd_phv(bus.out_rd_phv), .out_rd_phv_wr(bus.out_rd_phv_wr),
    .out_rd_data(bus.out_rd_data), .out_rd_data_wr(bus.out_rd_data_wr),
    .out_rd_valid(bus.out_rd_valid), .out_rd_valid_wr(bus.out_rd_valid_wr),
    .in_rd_alf(bus.in_rd_alf), .gen_pkt_cnt(cnt)
  );

  always @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
    rd_cnt <= rd_cnt + (rd_en ? 1 : 0);
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_rd_data_wr) begin
      obs_q.push_back({bus.out_rd_valid_wr & bus.out_rd_valid, bus.out_rd_data});
      if (bus.out_rd_data[133:132] == WT_HEAD && last_tail >= 0)
        gap_q.push_back(cyc - last_tail - 1);
      if (bus.out_rd_valid_wr & bus.out_rd_valid) last_tail <= cyc;
    end
    if (bus.out_rd_phv_wr) obs_phv_q.push_back(bus.out_rd_phv);
  end

  task automatic chk(input string tag, input logic [1023:0] o, input logic [1023:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clear_inputs();
    start = 1'b0; finish = 1'b0; bypass = 1'b0;
    bus.in_rd_phv = '0; bus.in_rd_phv_wr = 1'b0;
    bus.in_rd_data = '0; bus.in_rd_data_wr = 1'b0;
    bus.in_rd_valid = 1'b0; bus.in_rd_valid_wr = 1'b0;
    bus.in_rd_alf = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_mem(input int tail_at);
    for (int a = 0; a < 128; a++) begin
      logic [1:0] t;
      t = (a == 0) ? WT_HEAD : ((a == tail_at) ? WT_TAIL : WT_BODY);
      mem[a] = {10'h2B5, t, $urandom, $urandom, $urandom, $urandom, 4'(a)};
    end
  endtask

  task automatic push_pkt(input int p, input int len);
    for (int a = 0; a < len; a++) begin
      logic [133:0] e;
      e = mem[a][133:0];
      if (a == 0) begin
`ifdef PGM_RD_SEQ_STAMP_EN
        e[31:0] = 32'(p);
`endif
        exp_phv_q.push_back('0);
      end
      if (a == len - 1) e[133:132] = WT_TAIL;
      exp_q.push_back({(a == len - 1), e});
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, " words"}, 1024'(obs_q.size()), 1024'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " word"}, 1024'(obs_q.pop_front()), 1024'(exp_q.pop_front()));
    chk({tag, " phvs"}, 1024'(obs_phv_q.size()), 1024'(exp_phv_q.size()));
    while (obs_phv_q.size() > 0 && exp_phv_q.size() > 0)
      chk({tag, " phv"}, obs_phv_q.pop_front(), exp_phv_q.pop_front());
    obs_q.delete(); exp_q.delete(); obs_phv_q.delete(); exp_phv_q.delete();
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int k = 0;
    while (cnt < 64'(n) && k < budget) begin @(negedge clk); k++; end
    chk("wait gen_pkt_cnt", 1024'(cnt >= 64'(n)), 1024'(1));
  endtask

  task automatic wait_addr(input int a, input int budget);
    int k = 0;
    while (!(rd_en && addr == 7'(a)) && k < budget) begin @(negedge clk); k++; end
    chk("wait rd addr", 1024'(rd_en && addr == 7'(a)), 1024'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_now();
    finish = 1'b1; repeat (3) @(negedge clk); finish = 1'b0; repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int tails;
    logic [133:0]  bw [3];
    logic [1023:0] bphv;

    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rd_en", 1024'(rd_en), '0);
    chk("reset addr", 1024'(addr), '0);
    chk("reset data", 1024'({bus.out_rd_data_wr, bus.out_rd_data}), '0);
    chk("reset valid", 1024'({bus.out_rd_valid, bus.out_rd_valid_wr}), '0);
    chk("reset phv", {bus.out_rd_phv[1022:0], bus.out_rd_phv_wr}, '0);
    chk("reset cnt", 1024'(cnt), '0);
    rst_n = 1'b1;
    bus.in_rd_alf = 1'b1; #1;
    chk("alf passthrough hi", 1024'(bus.out_rd_alf), 1024'(1));
    bus.in_rd_alf = 1'b0; #1;
    chk("alf passthrough lo", 1024'(bus.out_rd_alf), '0);

    // Finish mid-packet: tail still emitted, then no further reads.
    do_reset();
    load_mem(3);
    push_pkt(0, 4);
    pulse_start();
    wait_addr(2, 50);
    finish = 1'b1; @(negedge clk); finish = 1'b0;
    repeat (10) @(negedge clk);
    snap = rd_cnt;
    repeat (20) @(negedge clk);
    chk("finish no rd_en", 1024'(rd_cnt - snap), '0);
    chk("finish cnt", 1024'(cnt), 1024'(1));
    drain("finish");

    // Bypass right after finish: proves the FSM is back in IDLE.
    bphv = '0;
    for (int i = 0; i < 16; i++) bphv[i*32 +: 32] = $urandom;
    bw[0] = {WT_HEAD, $urandom, $urandom, $urandom, $urandom, 4'h1};
    bw[1] = {WT_BODY, $urandom, $urandom, $urandom, $urandom, 4'h2};
    bw[2] = {WT_TAIL, $urandom, $urandom, $urandom, $urandom, 4'h3};
    bypass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_rd_data = bw[i]; bus.in_rd_data_wr = 1'b1;
      bus.in_rd_phv_wr = (i == 0); bus.in_rd_phv = bphv;
      bus.in_rd_valid = (i == 2); bus.in_rd_valid_wr = (i == 2);
      exp_q.push_back({(i == 2), bw[i]});
      if (i == 0) exp_phv_q.push_back(bphv);
      @(negedge clk);
      chk("bypass latency", 1024'({bus.out_rd_data_wr, bus.out_rd_data}), 1024'({1'b1, bw[i]}));
      chk("bypass valid", 1024'({bus.out_rd_valid, bus.out_rd_valid_wr}), 1024'((i == 2) ? 2'b11 : 2'b00));
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("bypass no rd_en", 1024'(rd_en), '0);
    drain("bypass");

    // Generate: three 4-word packets; bypass strobes injected mid-run are ignored.
    do_reset();
    load_mem(3);
    for (int p = 0; p < 3; p++) push_pkt(p, 4);
    pulse_start();
    wait_addr(1, 50);
    bypass = 1'b1; bus.in_rd_data = bw[2]; bus.in_rd_data_wr = 1'b1;
    bus.in_rd_valid = 1'b1; bus.in_rd_valid_wr = 1'b1;
    @(negedge clk);
    clear_inputs();
    wait_pkts(3, 200);
    finish_now();
    chk("gen cnt", 1024'(cnt), 1024'(3));
    drain("gen");

    // Backpressure mid-packet: packet completes, next header waits for alf low.
    do_reset();
    load_mem(3);
    push_pkt(0, 4);
    pulse_start();
    wait_addr(2, 50);
    bus.in_rd_alf = 1'b1;
    repeat (10) @(negedge clk);
    snap = rd_cnt;
    repeat (10) @(negedge clk);
    chk("alf hold cnt", 1024'(cnt), 1024'(1));
    chk("alf hold words", 1024'(obs_q.size()), 1024'(4));
    chk("alf hold no rd_en", 1024'(rd_cnt - snap), '0);
    push_pkt(1, 4);
    bus.in_rd_alf = 1'b0;
    wait_pkts(2, 100);
    finish_now();
    drain("alf");

    // Start and finish together: finish wins.
    do_reset();
    snap = rd_cnt;
    start = 1'b1; finish = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0; finish = 1'b0;
    repeat (5) @(negedge clk);
    chk("start+finish rd_en", 1024'(rd_cnt - snap), '0);
    chk("start+finish cnt", 1024'(cnt), '0);
    chk("start+finish words", 1024'(obs_q.size()), '0);

    // Wrap: no tail stored, word 127 is forced to tail.
    do_reset();
    load_mem(-1);
    push_pkt(0, 128);
    pulse_start();
    wait_pkts(1, 400);
    finish_now();
    chk("wrap cnt", 1024'(cnt), 1024'(1));
    drain("wrap");

    // Asynchronous reset in the middle of a packet.
    pulse_start();
    wait_addr(20, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async rd", 1024'({rd_en, addr}), '0);
    chk("async data", 1024'({bus.out_rd_data_wr, bus.out_rd_data}), '0);
    chk("async valid", 1024'({bus.out_rd_valid, bus.out_rd_valid_wr}), '0);
    chk("async phv", {bus.out_rd_phv[1022:0], bus.out_rd_phv_wr}, '0);
    chk("async cnt", 1024'(cnt), '0);
    tails = 0;
    foreach (obs_q[i]) if (obs_q[i][134]) tails++;
    chk("async no tail", 1024'(tails), '0);
    obs_q.delete(); obs_phv_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    snap = rd_cnt;
    repeat (10) @(negedge clk);
    chk("post reset idle", 1024'(rd_cnt - snap), '0);

    chk("gaps seen", 1024'(gap_q.size() >= 3), 1024'(1));
    while (gap_q.size() > 0) chk("inter-packet gap", 1024'(gap_q.pop_front() >= 1), 1024'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pgm_rd.md
PGM_RD -- requirements
Module: pgm_rd

Interface
REQ-001 SHALL have parameter PLATFORM, default "Xilinx", target vendor tag.
REQ-002 SHALL have parameter LMID, default 8'd63, local module ID.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports in_rd_phv  input  1024 and in_rd_phv_wr  input  1, the bypass PHV and its strobe.
REQ-007 SHALL have ports in_rd_data  input  134, in_rd_data_wr  input  1, in_rd_valid  input  1 and in_rd_valid_wr  input  1, the bypass packet words and their strobes.
REQ-008 SHALL have port out_rd_alf  output  1  upstream almost-full, equal to in_rd_alf.
REQ-009 SHALL have ports pgm_bypass_flag, pgm_sent_start_flag and pgm_sent_finish_flag, each  input  1, the mode flags from the write stage.
REQ-010 SHALL have ports rd2ram_rd_en  output  1 and rd2ram_addr  output  7, the PGM_RAM read request.
REQ-011 SHALL have port ram2rd_rdata  input  144  PGM_RAM read data, returned 1 cycle after the read request.
REQ-012 SHALL have ports out_rd_phv  output  1024, out_rd_phv_wr  output  1, out_rd_data  output  134, out_rd_data_wr  output  1, out_rd_valid  output  1 and out_rd_valid_wr  output  1, the downstream packet stream.
REQ-013 SHALL have port in_rd_alf  input  1  downstream almost-full.
REQ-014 SHALL have port gen_pkt_cnt  output  64  count of generated packets.

Function
REQ-015 SHALL implement states IDLE, BYPASS, RD, GAP and DRAIN.
REQ-016 IDLE: when pgm_bypass_flag=1 and in_rd_data_wr=1, SHALL go to BYPASS; when pgm_sent_start_flag=1 and pgm_sent_finish_flag=0, SHALL go to RD with rd2ram_addr=0.
REQ-017 BYPASS: SHALL register the in_rd_* inputs to the out_rd_* outputs with 1-cycle latency, and SHALL return to IDLE after forwarding a word with [133:132]=2'b10.
REQ-018 RD: SHALL assert rd2ram_rd_en each cycle and increment rd2ram_addr.
REQ-019 RD: the returned word, bits [133:0], SHALL appear on out_rd_data with out_rd_data_wr=1 one cycle after its read.
REQ-020 RD: on the header word ([133:132]=2'b01), SHALL set out_rd_phv=0 and out_rd_phv_wr=1.
REQ-021 RD tail: on a returned word with [133:132]=2'b10, SHALL set out_rd_valid=1 and out_rd_valid_wr=1, increment gen_pkt_cnt, reset the address to 0 and go to GAP.
REQ-022 RD wrap: SHALL stop reads at address 127; if word 127 is not a tail, SHALL force [133:132]=2'b10 on it and treat it as the tail.
REQ-023 GAP: SHALL idle at least 1 cycle, and SHALL stay while in_rd_alf=1; then SHALL go to RD.
REQ-024 in_rd_alf SHALL never split a packet; it gates only packet starts.
REQ-025 pgm_sent_finish_flag=1 in RD SHALL take effect after the current tail (go to DRAIN, then IDLE); in GAP or IDLE it SHALL take effect immediately.
REQ-026 If pgm_sent_start_flag and pgm_sent_finish_flag are asserted together, finish SHALL win and no packet SHALL be generated.
REQ-027 pgm_bypass_flag SHALL be ignored outside IDLE.
REQ-028 gen_pkt_cnt SHALL wrap modulo 2^64.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear all outputs, the address, gen_pkt_cnt and the state (to IDLE), abandoning any partial packet without emitting a tail.

Configuration
REQ-030 With PGM_RD_SEQ_STAMP_EN defined, each generated header word SHALL have bits [31:0] replaced by gen_pkt_cnt[31:0] taken before increment.
REQ-031 Without PGM_RD_SEQ_STAMP_EN, stored words SHALL be emitted unchanged; bypass words are never stamped in either case.

Structure
REQ-032 A shared package SHALL hold the state encodings, the 2'b01/2'b11/2'b10 word-type constants, and the RAM depth/width constants (128 x 144).
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 Bypass: a 3-word packet (01,11,10) with pgm_bypass_flag=1 SHALL be output identically 1 cycle later, with out_rd_valid=1 on the tail.
REQ-035 Generate: RAM holding 4 words (tail at address 3), start pulse SHALL produce repeated 4-word packets with >=1 idle cycle between them; after 3 packets, gen_pkt_cnt=3.
REQ-036 Backpressure: in_rd_alf=1 asserted mid-packet SHALL let the packet complete, after which no header is emitted until in_rd_alf=0.
REQ-037 Finish: finish asserted at word 2 of 4 SHALL let the tail at word 3 be emitted, then the state SHALL return to IDLE and no further rd_en occurs.
REQ-038 Wrap: RAM with no tail SHALL produce a 128-word packet whose word 127 has [133:132]=2'b10.
REQ-039 Reset: rst_n low mid-packet SHALL zero all outputs asynchronously, and gen_pkt_cnt SHALL read 0.
